// File: rtl/disp_scan_ctrl.sv
// Eight-digit multiplexed display scanner with a guard-banded slot timer,
// a two-stage (pending/active) image buffer swapped only at frame boundaries, and frame-based blinking.
module disp_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  points,
    input  logic [7:0]  le,
    input  logic [7:0]  blink,
    output logic        load_ack,
    output logic [7:0]  an,
    output logic [3:0]  hex_o,
    output logic        point_o,
    output logic        le_o,
    output logic        flash_o,
    output logic        frame_tick
);

    localparam int             CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [9:0]     BLINK_MAX = 10'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  points;
        logic [7:0]  le;
        logic [7:0]  blink;
    } image_t;

    typedef enum logic [0:0] {
        PEND_EMPTY = 1'b0,
        PEND_FULL  = 1'b1
    } pend_state_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    dig_q, dig_d;
    logic [9:0]    bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [7:0]    an_q, an_d;
    logic          frame_tick_q, frame_tick_d;
    logic          load_ack_q, load_ack_d;
    pend_state_t   pend_state_q, pend_state_d;
    image_t        pend_img_q, pend_img_d;
    image_t        act_img_q, act_img_d;
    image_t        in_img_s;
    logic          slot_end_s;
    logic          boundary_s;
    logic          guard_s;
    logic [3:0]    hex_s;

    assign in_img_s = '{data: data, points: points, le: le, blink: blink};

    // Slot timer, digit index, registered anode pattern and blink phase.
    always_comb begin
        cnt_d        = cnt_q;
        dig_d        = dig_q;
        bcnt_d       = bcnt_q;
        phase_d      = phase_q;
        slot_end_s   = (cnt_q == CNT_MAX);
        boundary_s   = slot_end_s && (dig_q == 3'd7);
        frame_tick_d = boundary_s;
        if (slot_end_s) begin
            cnt_d = '0;
            dig_d = dig_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
            dig_d = dig_q;
        end
        // The anode register is loaded from next-state values so it lines up with cnt_q/dig_q.
        guard_s = (int'(cnt_d) < GUARD);
        if (guard_s) begin
            an_d = 8'hFF;
        end else begin
            an_d = ~(8'h01 << dig_d);
        end
        if (boundary_s) begin
            if (bcnt_q == BLINK_MAX) begin
                bcnt_d  = 10'd0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + 10'd1;
                phase_d = phase_q;
            end
        end else begin
            bcnt_d  = bcnt_q;
            phase_d = phase_q;
        end
    end

    // Pending-buffer control: capture on load when empty, hand over to active at a frame boundary.
    always_comb begin
        pend_state_d = pend_state_q;
        pend_img_d   = pend_img_q;
        act_img_d    = act_img_q;
        load_ack_d   = 1'b0;
        case (pend_state_q)
            PEND_EMPTY: begin
                if (load) begin
                    pend_img_d   = in_img_s;
                    pend_state_d = PEND_FULL;
                    load_ack_d   = 1'b1;
                end else begin
                    pend_state_d = PEND_EMPTY;
                end
            end
            PEND_FULL: begin
                // A load seen in the transfer cycle waits: acceptance needs an empty buffer.
                if (boundary_s) begin
                    act_img_d    = pend_img_q;
                    pend_state_d = PEND_EMPTY;
                end else begin
                    pend_state_d = PEND_FULL;
                end
            end
            default: begin
                pend_state_d = PEND_EMPTY;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            dig_q        <= 3'd0;
            bcnt_q       <= 10'd0;
            phase_q      <= 1'b0;
            an_q         <= 8'hFF;
            frame_tick_q <= 1'b0;
            load_ack_q   <= 1'b0;
            pend_state_q <= PEND_EMPTY;
            pend_img_q   <= '0;
            act_img_q    <= '0;
        end else begin
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            bcnt_q       <= bcnt_d;
            phase_q      <= phase_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
            load_ack_q   <= load_ack_d;
            pend_state_q <= pend_state_d;
            pend_img_q   <= pend_img_d;
            act_img_q    <= act_img_d;
        end
    end

    // Nibble select for the current digit.
    always_comb begin
        hex_s = 4'h0;
        case (dig_q)
            3'd0:    hex_s = act_img_q.data[3:0];
            3'd1:    hex_s = act_img_q.data[7:4];
            3'd2:    hex_s = act_img_q.data[11:8];
            3'd3:    hex_s = act_img_q.data[15:12];
            3'd4:    hex_s = act_img_q.data[19:16];
            3'd5:    hex_s = act_img_q.data[23:20];
            3'd6:    hex_s = act_img_q.data[27:24];
            3'd7:    hex_s = act_img_q.data[31:28];
            default: hex_s = 4'h0;
        endcase
    end

    assign an         = an_q;
    assign hex_o      = hex_s;
    assign point_o    = act_img_q.points[dig_q];
    assign le_o       = act_img_q.le[dig_q];
    assign flash_o    = ~(act_img_q.blink[dig_q] & phase_q);
    assign load_ack   = load_ack_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl: a cycle model keyed on clocks-since-reset pushes
// expected outputs to a scoreboard queue, popped and compared after each clock edge.
module tb_disp_scan_ctrl;

    localparam int SD = 4;
    localparam int GD = 1;
    localparam int BF = 2;
    localparam int FR = SD * 8;
    localparam int BP = FR * BF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [31:0] data = 32'h0;
    logic [7:0]  points = 8'h0;
    logic [7:0]  le = 8'h0;
    logic [7:0]  blink = 8'h0;
    logic        load_ack;
    logic [7:0]  an;
    logic [3:0]  hex_o;
    logic        point_o;
    logic        le_o;
    logic        flash_o;
    logic        frame_tick;

    disp_scan_ctrl #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data), .points(points),
        .le(le), .blink(blink), .load_ack(load_ack), .an(an), .hex_o(hex_o),
        .point_o(point_o), .le_o(le_o), .flash_o(flash_o), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] an;
        logic [3:0] hex;
        logic       pt;
        logic       le;
        logic       fl;
        logic       ft;
        logic       ack;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          k = 0;
    logic [31:0] m_data, p_data;
    logic [7:0]  m_pts, m_le, m_blk, p_pts, p_le, p_blk;
    logic        m_pv;
    logic        last_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic model_reset();
        k = 0;
        m_data = 32'h0; m_pts = 8'h0; m_le = 8'h0; m_blk = 8'h0;
        p_data = 32'h0; p_pts = 8'h0; p_le = 8'h0; p_blk = 8'h0;
        m_pv = 1'b0;
        last_ack = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an"},   32'(an), 32'hFF);
        chk({tag, "_hex"},  32'(hex_o), 32'h0);
        chk({tag, "_pt"},   32'(point_o), 32'h0);
        chk({tag, "_le"},   32'(le_o), 32'h0);
        chk({tag, "_fl"},   32'(flash_o), 32'h1);
        chk({tag, "_ack"},  32'(load_ack), 32'h0);
        chk({tag, "_ft"},   32'(frame_tick), 32'h0);
    endtask

    task automatic tick(input logic ld, input logic [31:0] d, input logic [7:0] p,
                        input logic [7:0] l, input logic [7:0] b);
        exp_t e;
        int   dg;
        load = ld; data = d; points = p; le = l; blink = b;
        e.ack = ld && !m_pv;
        if (m_pv && (k % FR == FR - 1)) begin
            m_data = p_data; m_pts = p_pts; m_le = p_le; m_blk = p_blk;
            m_pv = 1'b0;
        end
        if (e.ack) begin
            p_data = d; p_pts = p; p_le = l; p_blk = b;
            m_pv = 1'b1;
        end
        k++;
        dg = (k / SD) % 8;
        e.an  = ((k % SD) < GD) ? 8'hFF : ~(8'h01 << dg);
        e.hex = 4'(m_data >> (4 * dg));
        e.pt  = m_pts[dg];
        e.le  = m_le[dg];
        e.fl  = ~(m_blk[dg] & 1'((k / BP) % 2));
        e.ft  = (k % FR == 0);
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("an", 32'(an), 32'(e.an));
        chk("hex_o", 32'(hex_o), 32'(e.hex));
        chk("point_o", 32'(point_o), 32'(e.pt));
        chk("le_o", 32'(le_o), 32'(e.le));
        chk("flash_o", 32'(flash_o), 32'(e.fl));
        chk("frame_tick", 32'(frame_tick), 32'(e.ft));
        chk("load_ack", 32'(load_ack), 32'(e.ack));
        last_ack = e.ack;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        load = 1'b1; data = 32'hDEADBEEF; le = 8'hFF;
        @(negedge clk);
        chk_reset_outputs("rst_load");
        load = 1'b0;
        rst_n = 1'b1;

        // Idle frame: guard slots, digit walk, single frame_tick, blank digits.
        repeat (FR + 2) tick(1'b0, 32'h0, 8'h0, 8'h0, 8'h0);

        // Single image, shown from the next frame.
        tick(1'b1, 32'h76543210, 8'h01, 8'hFF, 8'h00);
        repeat (FR + 8) tick(1'b0, 32'h0, 8'h0, 8'h0, 8'h0);

        // Image A accepted, image B held until A moves to active.
        tick(1'b1, 32'h89ABCDEF, 8'hF0, 8'h0F, 8'h00);
        for (int i = 0; i < 2 * FR; i++) begin
            tick(1'b1, 32'h11223344, 8'h00, 8'hFF, 8'h04);
            if (last_ack) break;
        end
        repeat (4 * FR + 12) tick(1'b0, 32'h0, 8'h0, 8'h0, 8'h0);

        // Reset at dig 5, cnt 2 while an image is pending.
        while (k % FR != 2) tick(1'b0, 32'h0, 8'h0, 8'h0, 8'h0);
        tick(1'b1, 32'hFEDCBA98, 8'hAA, 8'hFF, 8'hFF);
        while (k % FR != 22) tick(1'b0, 32'h0, 8'h0, 8'h0, 8'h0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        chk_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        repeat (6) tick(1'b0, 32'h0, 8'h0, 8'h0, 8'h0);
        tick(1'b1, 32'h0F1E2D3C, 8'h81, 8'hFF, 8'h00);
        repeat (FR + 8) tick(1'b0, 32'h0, 8'h0, 8'h0, 8'h0);

        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
